// File: rtl/mem_arbiter.sv
// Two-requester arbiter that puts instruction fetches and data accesses onto one single-ported RAM.
// Data has priority, a streak limit protects pending fetches, and a watchdog aborts stalled accesses.
module mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic [1:0]  grant,
    output logic        err
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcount;

    logic dreq, i_act, d_act, timeout, i_done, d_done, d_grant;

    assign dreq    = dREN | dWEN;
    assign i_act   = (state == I_ACC) && iREN;
    assign d_act   = (state == D_ACC) && dreq;
    // The watchdog only fires for a request that is still being held.
    assign timeout = (i_act || d_act) && !ramready && (tcount == TW'(TIMEOUT - 1));
    assign i_done  = i_act && (ramready || timeout);
    assign d_done  = d_act && (ramready || timeout);
    assign d_grant = dreq && !(iREN && (streak == SW'(MAX_D_STREAK)));

    assign iwait = iREN && !i_done;
    assign dwait = dreq && !d_done;
    assign iload = (i_act && ramready) ? ramload : 32'h0;
    assign dload = (d_act && dREN && !dWEN && ramready) ? ramload : 32'h0;

    // RAM strobes follow the live request so a withdrawn request drops them at once.
    assign ramREN   = ((state == I_ACC) && iREN) || ((state == D_ACC) && dREN && !dWEN);
    assign ramWEN   = (state == D_ACC) && dWEN;
    assign ramaddr  = (state == I_ACC) ? iaddr : ((state == D_ACC) ? daddr : 32'h0);
    assign ramstore = (state == D_ACC) ? dstore : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            streak <= '0;
            tcount <= '0;
            err    <= 1'b0;
            grant  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    tcount <= '0;
                    if (d_grant) begin
                        state <= D_ACC;
                        grant <= 2'b10;
                        if (!iREN)
                            streak <= '0;
                        else if (streak != SW'(MAX_D_STREAK))
                            streak <= streak + SW'(1);
                    end else if (iREN) begin
                        state  <= I_ACC;
                        grant  <= 2'b01;
                        streak <= '0;
                    end
                end
                I_ACC: begin
                    if (!iREN || ramready || timeout) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else begin
                        tcount <= tcount + TW'(1);
                    end
                    if (timeout)
                        err <= 1'b1;
                end
                D_ACC: begin
                    if (!dreq || ramready || timeout) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else begin
                        tcount <= tcount + TW'(1);
                    end
                    if (timeout)
                        err <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
